// File: rtl/ldpc_3gpp_dec_llr_waddr_gen.sv
// ldpc_3gpp_dec_llr_waddr_gen: column-block-major LLR RAM write address generator and frame controller
module ldpc_3gpp_dec_llr_waddr_gen #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 32,
    parameter int pCOL_W  = 7,
    parameter int pZC_W   = 9
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic [pZC_W-1:0]   iused_zc,
    input  logic [pCOL_W-1:0]  iused_col,
    input  logic               ival,
    input  logic               isop,
    input  logic               ieop,
    input  logic [pDAT_W-1:0]  idat,
    input  logic               ibuf_release,
    output logic               ordy,
    output logic               owrite,
    output logic [pADDR_W-1:0] oLLR_waddr,
    output logic [pDAT_W-1:0]  oLLR_wdat,
    output logic               odone,
    output logic               oerr,
    output logic               ofull
);
    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    state_t              state_q, state_d;
    logic [pZC_W-1:0]    zc_cnt_q, zc_cnt_d, used_zc_q, used_zc_d;
    logic [pCOL_W-1:0]   col_cnt_q, col_cnt_d, used_col_q, used_col_d;
    logic [pADDR_W-1:0]  col_base_q, col_base_d, waddr_q, waddr_d;
    logic [pDAT_W-1:0]   wdat_q, wdat_d;
    logic                owrite_q, owrite_d, done_q, done_d, err_q, err_d;
    logic                acc, start, wr, zc_last, last, fin;
    logic [pZC_W-1:0]    uz, zc_cur;
    logic [pCOL_W-1:0]   uc, col_cur;
    logic [pADDR_W-1:0]  base_cur;

    assign ordy       = state_q != FULL;
    assign ofull      = state_q == FULL;
    assign owrite     = owrite_q;
    assign oLLR_waddr = waddr_q;
    assign oLLR_wdat  = wdat_q;
    assign odone      = done_q;
    assign oerr       = err_q;

    // An isop word starts a fresh frame from the live sizes; otherwise continue from the latched counters.
    always_comb begin
        acc        = ival & ordy & iclkena;
        start      = acc & isop;
        wr         = start | (acc & (state_q == WRITE));
        uz         = start ? iused_zc : used_zc_q;
        uc         = start ? iused_col : used_col_q;
        zc_cur     = start ? '0 : zc_cnt_q;
        col_cur    = start ? '0 : col_cnt_q;
        base_cur   = start ? '0 : col_base_q;
        zc_last    = zc_cur == uz - pZC_W'(1);
        last       = zc_last & (col_cur == uc - pCOL_W'(1));
        fin        = last | ieop;
        state_d    = state_q;
        zc_cnt_d   = zc_cnt_q;
        col_cnt_d  = col_cnt_q;
        col_base_d = col_base_q;
        used_zc_d  = used_zc_q;
        used_col_d = used_col_q;
        waddr_d    = waddr_q;
        wdat_d     = wdat_q;
        owrite_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (state_q == FULL && ibuf_release)
            state_d = IDLE;
        if (wr) begin
            used_zc_d  = uz;
            used_col_d = uc;
            owrite_d   = 1'b1;
            waddr_d    = base_cur + pADDR_W'(zc_cur);
            wdat_d     = idat;
            zc_cnt_d   = zc_last ? '0 : zc_cur + pZC_W'(1);
            col_cnt_d  = zc_last ? col_cur + pCOL_W'(1) : col_cur;
            col_base_d = zc_last ? base_cur + pADDR_W'(uz) : base_cur;
            state_d    = fin ? FULL : WRITE;
            done_d     = fin;
            err_d      = (start && state_q == WRITE) || (fin && !(last && ieop));
        end
    end

    // State register; clock enable freezes everything, reset discards any frame in progress.
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state_q    <= IDLE;
            zc_cnt_q   <= '0;
            col_cnt_q  <= '0;
            col_base_q <= '0;
            used_zc_q  <= '0;
            used_col_q <= '0;
            waddr_q    <= '0;
            wdat_q     <= '0;
            owrite_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (iclkena) begin
            state_q    <= state_d;
            zc_cnt_q   <= zc_cnt_d;
            col_cnt_q  <= col_cnt_d;
            col_base_q <= col_base_d;
            used_zc_q  <= used_zc_d;
            used_col_q <= used_col_d;
            waddr_q    <= waddr_d;
            wdat_q     <= wdat_d;
            owrite_q   <= owrite_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_ldpc_3gpp_dec_llr_waddr_gen.sv
// tb_ldpc_3gpp_dec_llr_waddr_gen: directed vector bench for the LLR write address generator
module tb_ldpc_3gpp_dec_llr_waddr_gen;
    logic        clk = 1'b0, ireset = 1'b0, iclkena = 1'b1;
    logic [8:0]  iused_zc = '0;
    logic [6:0]  iused_col = '0;
    logic        ival = 1'b0, isop = 1'b0, ieop = 1'b0, ibuf_release = 1'b0;
    logic [31:0] idat = '0;
    logic        ordy, owrite, odone, oerr, ofull;
    logic [7:0]  oLLR_waddr;
    logic [31:0] oLLR_wdat;

    int checks = 0, errors = 0;
    int n_done = 0, n_err = 0;
    logic done_wr = 1'b0, err_done = 1'b0;
    logic [7:0] done_addr = '0;
    logic [7:0] alog[$];
    logic [31:0] dlog[$];

    typedef struct {
        int zc; int col; int n; int eop; bit gap; int exp_wr; bit exp_err;
    } vec_t;
    vec_t tbl[7];

    ldpc_3gpp_dec_llr_waddr_gen dut (
        .iclk(clk), .ireset(ireset), .iclkena(iclkena), .iused_zc(iused_zc),
        .iused_col(iused_col), .ival(ival), .isop(isop), .ieop(ieop), .idat(idat),
        .ibuf_release(ibuf_release), .ordy(ordy), .owrite(owrite),
        .oLLR_waddr(oLLR_waddr), .oLLR_wdat(oLLR_wdat), .odone(odone), .oerr(oerr),
        .ofull(ofull)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (owrite) begin
            alog.push_back(oLLR_waddr);
            dlog.push_back(oLLR_wdat);
        end
        if (odone) begin
            n_done++;
            done_wr = owrite;
            done_addr = oLLR_waddr;
        end
        if (oerr) begin
            n_err++;
            err_done = odone;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic s, input logic e, input logic [31:0] d, input logic rel);
        ival = v; isop = s; ieop = e; idat = d; ibuf_release = rel;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alog.delete(); dlog.delete();
        n_done = 0; n_err = 0; done_wr = 1'b0; err_done = 1'b0; done_addr = '0;
    endtask

    task automatic run_row(input string nm, input vec_t v);
        int bad;
        clr();
        iused_zc = 9'(v.zc);
        iused_col = 7'(v.col);
        for (int w = 0; w < v.n; w++) begin
            if (w == 1) begin
                iused_zc = 9'd7;
                iused_col = 7'd2;
            end
            cyc(1'b1, w == 0, w == v.eop, 32'hA000 + 32'(w), 1'b0);
            if (v.gap) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk({nm, " writes"}, alog.size(), v.exp_wr);
        bad = 0;
        foreach (alog[k])
            if (alog[k] !== 8'(k) || dlog[k] !== 32'hA000 + 32'(k)) bad++;
        chk({nm, " addr/data seq"}, bad, 0);
        chk({nm, " done count"}, n_done, 1);
        chk({nm, " err count"}, n_err, 32'(v.exp_err));
        chk({nm, " done with write"}, done_wr, 1);
        chk({nm, " done addr"}, done_addr, v.exp_wr - 1);
        chk({nm, " ofull"}, ofull, 1);
        chk({nm, " ordy in full"}, ordy, 0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk({nm, " ordy after release"}, ordy, 1);
        chk({nm, " ofull after release"}, ofull, 0);
    endtask

    initial begin
        tbl[0] = '{zc: 4, col: 3, n: 12, eop: 11, gap: 0, exp_wr: 12, exp_err: 0};
        tbl[1] = '{zc: 4, col: 3, n: 12, eop: 11, gap: 1, exp_wr: 12, exp_err: 0};
        tbl[2] = '{zc: 1, col: 5, n: 5,  eop: 4,  gap: 0, exp_wr: 5,  exp_err: 0};
        tbl[3] = '{zc: 4, col: 3, n: 12, eop: 6,  gap: 0, exp_wr: 7,  exp_err: 1};
        tbl[4] = '{zc: 4, col: 3, n: 12, eop: -1, gap: 0, exp_wr: 12, exp_err: 1};
        tbl[5] = '{zc: 1, col: 1, n: 1,  eop: 0,  gap: 0, exp_wr: 1,  exp_err: 0};
        tbl[6] = '{zc: 3, col: 2, n: 8,  eop: 7,  gap: 1, exp_wr: 6,  exp_err: 1};

        repeat (3) @(posedge clk);
        #1;
        ireset = 1'b1;
        chk("reset ordy", ordy, 1);
        chk("reset owrite", owrite, 0);
        chk("reset odone", odone, 0);
        chk("reset oerr", oerr, 0);
        chk("reset ofull", ofull, 0);
        chk("reset waddr", oLLR_waddr, 0);

        clr();
        cyc(1'b1, 1'b0, 1'b0, 32'h1234, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("idle no-sop dropped", alog.size(), 0);

        for (int r = 0; r < 7; r++) run_row($sformatf("row%0d", r), tbl[r]);

        clr();
        iused_zc = 9'd4;
        iused_col = 7'd3;
        for (int w = 0; w < 5; w++) cyc(1'b1, w == 0, 1'b0, 32'(w), 1'b0);
        for (int w = 0; w < 12; w++) cyc(1'b1, w == 0, w == 11, 32'(w), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("abort writes", alog.size(), 17);
        chk("abort restart addr", alog.size() > 5 ? alog[5] : 8'hFF, 0);
        chk("abort final addr", alog.size() > 16 ? alog[16] : 8'hFF, 11);
        chk("abort err count", n_err, 1);
        chk("abort err without done", err_done, 0);
        chk("abort done count", n_done, 1);
        chk("abort ofull", ofull, 1);

        clr();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h5555, i == 4);
            if (i == 3) chk("full ordy before release", ordy, 0);
            if (i == 4) chk("full ordy after release", ordy, 1);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("full no writes", alog.size(), 0);
        chk("full ofull cleared", ofull, 0);

        clr();
        cyc(1'b1, 1'b1, 1'b0, 32'h77, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h78, 1'b0);
        ireset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 32'h79, 1'b0);
        ireset = 1'b1;
        chk("midreset owrite", owrite, 0);
        chk("midreset waddr", oLLR_waddr, 0);
        chk("midreset ordy", ordy, 1);
        chk("midreset ofull", ofull, 0);
        cyc(1'b1, 1'b0, 1'b0, 32'h7A, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("midreset writes", alog.size(), 2);
        chk("midreset no done", n_done, 0);
        chk("midreset no err", n_err, 0);

        run_row("post-reset", '{zc: 2, col: 2, n: 4, eop: 3, gap: 0, exp_wr: 4, exp_err: 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ldpc_3gpp_dec_llr_waddr_gen.md
Name: ldpc_3gpp_dec_LLR_waddr_gen

Overview:
Write-side address generator and frame controller for the decoder's LLR RAM. It accepts the incoming channel-LLR word stream and produces the RAM write strobe, address and data. Layout is column-block major: address = col*used_zc + zc_idx. This is the same layout the decoder's LLR read path consumes in both cnode and vnode modes. After a full frame is written it holds the buffer until the decoder releases it.

Parameters:
pADDR_W, 8, LLR RAM address width; address arithmetic wraps modulo 2^pADDR_W.
pDAT_W, 32, LLR word width passed through to the RAM.
pCOL_W, 7, width of the column-block count (BG1 maximum is 68).

Ports:
iclk  in  1  clock
ireset  in  1  synchronous reset, active-low
iclkena  in  1  clock enable; low freezes all state and outputs
iused_zc  in  hb_zc_t  lifting size, sampled at the frame's first accepted word
iused_col  in  pCOL_W  column blocks per frame (1..68), sampled with iused_zc
ival  in  1  input word valid
isop  in  1  first word of frame
ieop  in  1  last word of frame
idat  in  pDAT_W  LLR word
ibuf_release  in  1  decoder has finished with the buffer
ordy  out  1  block can accept a word this cycle
owrite  out  1  RAM write enable
oLLR_waddr  out  pADDR_W  RAM write address
oLLR_wdat  out  pDAT_W  RAM write data
odone  out  1  one-cycle pulse, frame complete
oerr  out  1  one-cycle pulse, framing error (coincides with odone or with an aborted frame)
ofull  out  1  buffer holds a complete frame

Behaviour:
- Reset (ireset==0 at a clock edge): state IDLE, all counters 0, owrite=0, odone=0, oerr=0, ofull=0, oLLR_waddr=0. ordy is combinational from state, so ordy=1 after reset.
- Accept: a word is accepted when ival & ordy & iclkena.
- Write latency: 1 cycle. owrite, oLLR_waddr and oLLR_wdat are registered from the accepted word.
- Counters:
  - zc_cnt: 0..used_zc-1.
  - col_cnt: 0..used_col-1.
  - col_base: += used_zc whenever zc_cnt wraps.
  - Write address = col_base + zc_cnt.
  - used_zc=1: every word advances col_cnt and col_base (col_base steps by 1).
- ordy: 1 in IDLE and WRITE, 0 in FULL.
- States:
  - IDLE:
    - An accepted word with isop latches iused_zc and iused_col, writes address 0, sets zc_cnt=1 (or col_cnt=1 when used_zc=1), and moves to WRITE.
    - An accepted word without isop is dropped, no write.
    - isop&ieop on the first word: if used_zc*used_col==1 the frame completes normally; otherwise the early-eop rule applies.
  - WRITE:
    - Each accepted word is written and the counters advance.
    - The last word is zc_cnt==used_zc-1 and col_cnt==used_col-1.
    - Last word with ieop=1: FULL, odone=1 one cycle later, aligned with the last owrite.
    - Last word with ieop=0: the frame still ends → FULL, odone=1 and oerr=1.
    - Early ieop (before the last word): word written, then FULL with odone=1 and oerr=1.
    - Accepted isop in WRITE: current frame aborted, oerr=1 (odone=0), counters restart and the word is written at address 0 as a new frame.
  - FULL:
    - ofull=1, ordy=0, input ignored.
    - ibuf_release=1 → IDLE on the next cycle (ofull=0).
    - ibuf_release outside FULL is ignored.
- iused_zc / iused_col changes mid-frame have no effect until the next isop.
- Reset mid-frame: the frame is discarded with no odone and no oerr.
- Address overflow past 2^pADDR_W wraps silently; the integrator must size pADDR_W to at least clog2(68*384).

Test Plan:
1. used_zc=4, used_col=3, 12 back-to-back words with isop on word0, ieop on word11 → owrite addresses 0..11 in order; odone=1, oerr=0 on the cycle of addr 11; ofull=1, ordy=0.
2. Same frame with ival toggling 1/0 every cycle → identical address sequence with gaps; no duplicated or skipped addresses.
3. used_zc=1, used_col=5 → addresses 0,1,2,3,4; done after 5 words.
4. used_zc=4, used_col=3 with ieop on word 6 → 7 writes (addresses 0..6); odone=1 and oerr=1 together; then FULL.
5. isop again at word 5 → oerr pulse with odone=0; the new word is written at address 0 and a subsequent full 12-word frame completes cleanly.
6. In FULL, drive ival for 10 cycles and pulse ibuf_release at cycle 5 → no owrite during FULL; ordy=1 from the cycle after release. Then assert ireset=0 for one cycle mid-frame → all outputs return to reset values and no odone is produced.
